io_bus_controller: RTL
======================

Name: io_bus_controller

Overview:
- Sequences every CPU access to the one-hot mapped IO page: 20 word-address bits, one bit per device register, including LEDs, UART, OLED, SD card, buttons, FGA and the hardware-config registers.
- Validates the one-hot address, waits on the target device's busy flag, and issues exactly one single-cycle read or write strobe.
- Captures read data and returns a one-cycle completion to the CPU.
- Records illegal-address and timeout faults in sticky flags.
- Sits between the CPU memory interface and the OR-combined device read bus.

Parameters:
- NUM_IO_BITS, 20, width of the one-hot IO address field.
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting on dev_busy before the access is aborted.
- TIMEOUT_WIDTH, 8, width of the wait counter; must satisfy 2^TIMEOUT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  NUM_IO_BITS  one-hot IO register select (word-address bits of the IO page).
- cpu_rd  in  1  read request pulse; sampled only while cpu_busy=0.
- cpu_wr  in  1  write request pulse; sampled only while cpu_busy=0.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data; valid in the cycle cpu_done=1.
- cpu_busy  out  1  high from the cycle after acceptance through the cpu_done cycle.
- cpu_done  out  1  single-cycle completion pulse.
- dev_sel  out  NUM_IO_BITS  latched one-hot select; nonzero only during the strobe cycle.
- dev_rd  out  1  single-cycle read strobe.
- dev_wr  out  1  single-cycle write strobe.
- dev_wdata  out  32  latched write data.
- dev_rdata  in  32  OR-combined device read data; combinational on dev_sel/dev_rd.
- dev_busy  in  NUM_IO_BITS  per-device busy flags, for example UART sending or SD card shifting.
- err_clear  in  1  clears both sticky error flags.
- err_illegal  out  1  sticky flag: zero-hot or multi-hot address, or cpu_rd and cpu_wr high together.
- err_timeout  out  1  sticky flag: access aborted after TIMEOUT_CYCLES.

Behaviour:
- Reset: state=IDLE, wait counter=0, every output 0, sticky flags 0. Reset mid-access aborts the access; no strobe is issued and no cpu_done follows.
- FSM states: IDLE, WAIT, STROBE, RESP.
- IDLE, cycle T, cpu_rd or cpu_wr high:
  - Latch address, write data and operation.
  - If the address is one-hot and the request is not rd+wr together, go to WAIT.
  - Otherwise set err_illegal and go to RESP with rdata_q=0.
- WAIT:
  - If (dev_busy & sel_q)==0, go to STROBE.
  - Otherwise increment the wait counter. When it equals TIMEOUT_CYCLES, set err_timeout, load rdata_q=0 and go to RESP without a strobe.
  - The wait counter clears on entry to WAIT.
- STROBE, exactly one cycle:
  - dev_sel=sel_q, plus dev_rd or dev_wr=1.
  - Reads: rdata_q <= dev_rdata in this same cycle.
  - Go to RESP.
- RESP, one cycle: cpu_done=1, cpu_rdata=rdata_q, then return to IDLE.
- cpu_rdata holds its value until the next cpu_done.
- Best-case latency with a non-busy device: request at T, WAIT at T+1, strobe at T+2, cpu_done at T+3.
- Illegal access: cpu_done at T+2, no strobe.
- Requests arriving while cpu_busy=1 are ignored; they are not queued and raise no error.
- A new request is accepted in the cycle after cpu_done (IDLE).
- dev_busy rising after the strobe has no effect on the current access.
- err_clear and an error set in the same cycle: set wins.
- Each flag stays 1 until err_clear. Multiple errors stay at 1; there is no count.
- dev_wdata holds the latched value outside strobes.
- dev_sel, dev_rd and dev_wr are 0 in every state except STROBE.

Decomposition:
- Shared package io_map_pkg:
  - NUM_IO_BITS.
  - IO bit index constants: LEDS=0, UART_DAT=1, UART_CNTL=2, SSD1351_CNTL=3, SSD1351_CMD=4, SSD1351_DAT=5, SSD1351_DAT16=6, MAX7219_DAT=7, SDCARD=8, BUTTONS=9, FGA_CNTL=10, FGA_DAT=11, HW_CONFIG_RAM=17, HW_CONFIG_DEVICES=18, HW_CONFIG_CPUINFO=19.
  - FSM state enum.
- One sub-module, io_onehot_check: combinational; outputs is_onehot for a NUM_IO_BITS vector, computed as (v != 0) && ((v & (v-1)) == 0).

Test Plan:
- Read LEDS: cpu_addr=20'h00001, dev_busy=0, dev_rdata=32'h0000_000A -> dev_rd and dev_sel=1 at T+2; cpu_done at T+3 with cpu_rdata=32'h0000_000A; flags stay 0.
- Write UART_DAT with dev_busy[1] high for 5 cycles: cpu_wdata=32'h41 -> exactly one dev_wr, occurring after busy falls, with dev_wdata=32'h41 and dev_sel=20'h00002; cpu_done one cycle later.
- Illegal address 20'h00003 -> no strobe; cpu_done at T+2, cpu_rdata=0, err_illegal=1. Then err_clear -> err_illegal=0. Repeat with cpu_addr=0 and with cpu_rd+cpu_wr together: same result.
- Timeout: dev_busy[8] held high, read SDCARD -> no strobe; err_timeout=1 and cpu_done 255 wait cycles after entering WAIT; cpu_rdata=0.
- Read HW_CONFIG_RAM (bit 17), dev_rdata=6144 -> cpu_rdata=32'd6144. During the access, pulse cpu_wr to LEDS -> pulse ignored; exactly one strobe occurs in total.
- Reset asserted in WAIT with dev_busy high -> all outputs 0 the next cycle; no later dev_rd, dev_wr or cpu_done.

Source files
------------

// File: rtl/io_map_pkg.sv
// Shared IO page map: one-hot register bit positions and controller state encoding.
package io_map_pkg;

    localparam int unsigned NUM_IO_BITS = 20;

    // Bit index of each device register within the one-hot IO word address
    localparam int unsigned LEDS              = 0;
    localparam int unsigned UART_DAT          = 1;
    localparam int unsigned UART_CNTL         = 2;
    localparam int unsigned SSD1351_CNTL      = 3;
    localparam int unsigned SSD1351_CMD       = 4;
    localparam int unsigned SSD1351_DAT       = 5;
    localparam int unsigned SSD1351_DAT16     = 6;
    localparam int unsigned MAX7219_DAT       = 7;
    localparam int unsigned SDCARD            = 8;
    localparam int unsigned BUTTONS           = 9;
    localparam int unsigned FGA_CNTL          = 10;
    localparam int unsigned FGA_DAT           = 11;
    localparam int unsigned HW_CONFIG_RAM     = 17;
    localparam int unsigned HW_CONFIG_DEVICES = 18;
    localparam int unsigned HW_CONFIG_CPUINFO = 19;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STROBE = 2'd2,
        ST_RESP   = 2'd3
    } io_state_e;

endpackage

// File: rtl/io_onehot_check.sv
// Flags whether a select vector has exactly one bit set.
module io_onehot_check #(
    parameter int unsigned W = 20
) (
    input  logic [W-1:0] v,
    output logic         is_onehot
);

    // Nonzero and clearing the lowest set bit leaves nothing behind
    always_comb begin
        is_onehot = (v != '0) && ((v & (v - W'(1))) == '0);
    end

endmodule

// File: rtl/io_bus_controller.sv
// Sequences CPU accesses to the one-hot IO page: validate, wait on device
// busy, issue a single strobe, return a one-cycle completion.
module io_bus_controller #(
    parameter int unsigned NUM_IO_BITS    = 20,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_IO_BITS-1:0] cpu_addr,
    input  logic                   cpu_rd,
    input  logic                   cpu_wr,
    input  logic [31:0]            cpu_wdata,
    output logic [31:0]            cpu_rdata,
    output logic                   cpu_busy,
    output logic                   cpu_done,
    output logic [NUM_IO_BITS-1:0] dev_sel,
    output logic                   dev_rd,
    output logic                   dev_wr,
    output logic [31:0]            dev_wdata,
    input  logic [31:0]            dev_rdata,
    input  logic [NUM_IO_BITS-1:0] dev_busy,
    input  logic                   err_clear,
    output logic                   err_illegal,
    output logic                   err_timeout
);

    import io_map_pkg::*;

    io_state_e                state_q;
    logic [NUM_IO_BITS-1:0]   sel_q;
    logic [NUM_IO_BITS-1:0]   dev_sel_q;
    logic                     op_wr_q;
    logic                     abort_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     dev_rd_q;
    logic                     dev_wr_q;
    logic                     err_illegal_q;
    logic                     err_timeout_q;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt_q;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt_d;
    logic [31:0]              rdata_q;
    logic [31:0]              wdata_q;
    logic                     addr_onehot;
    logic                     req;
    logic                     req_legal;

    io_onehot_check #(
        .W (NUM_IO_BITS)
    ) u_onehot (
        .v         (cpu_addr),
        .is_onehot (addr_onehot)
    );

    assign req        = cpu_rd | cpu_wr;
    assign req_legal  = addr_onehot & ~(cpu_rd & cpu_wr);
    assign wait_cnt_d = wait_cnt_q + TIMEOUT_WIDTH'(1);

    // Access sequencer; every output comes straight from a register.
    // Illegal requests pass through WAIT for one cycle flagged as aborted,
    // so their completion lands two cycles after the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            dev_sel_q     <= '0;
            op_wr_q       <= 1'b0;
            abort_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            dev_rd_q      <= 1'b0;
            dev_wr_q      <= 1'b0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
            rdata_q       <= '0;
            wdata_q       <= '0;
        end else begin
            done_q    <= 1'b0;
            dev_rd_q  <= 1'b0;
            dev_wr_q  <= 1'b0;
            dev_sel_q <= '0;

            // Clear first so an error raised below in the same cycle wins
            if (err_clear) begin
                err_illegal_q <= 1'b0;
                err_timeout_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        sel_q      <= cpu_addr;
                        wdata_q    <= cpu_wdata;
                        op_wr_q    <= cpu_wr;
                        busy_q     <= 1'b1;
                        wait_cnt_q <= '0;
                        abort_q    <= ~req_legal;
                        state_q    <= ST_WAIT;
                        if (!req_legal) begin
                            err_illegal_q <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (abort_q) begin
                        rdata_q <= '0;
                        done_q  <= 1'b1;
                        state_q <= ST_RESP;
                    end else if ((dev_busy & sel_q) == '0) begin
                        dev_sel_q <= sel_q;
                        dev_rd_q  <= ~op_wr_q;
                        dev_wr_q  <= op_wr_q;
                        state_q   <= ST_STROBE;
                    end else if (wait_cnt_d == TIMEOUT_WIDTH'(TIMEOUT_CYCLES)) begin
                        wait_cnt_q    <= wait_cnt_d;
                        err_timeout_q <= 1'b1;
                        rdata_q       <= '0;
                        done_q        <= 1'b1;
                        state_q       <= ST_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                ST_STROBE: begin
                    rdata_q <= op_wr_q ? 32'h0 : dev_rdata;
                    done_q  <= 1'b1;
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata   = rdata_q;
    assign cpu_busy    = busy_q;
    assign cpu_done    = done_q;
    assign dev_sel     = dev_sel_q;
    assign dev_rd      = dev_rd_q;
    assign dev_wr      = dev_wr_q;
    assign dev_wdata   = wdata_q;
    assign err_illegal = err_illegal_q;
    assign err_timeout = err_timeout_q;

endmodule
